// File: rtl/bus2_arb_if.sv
// bus2_arb_if: groups the two requester handshakes and the memory-side line bus
// of the bus2 arbiter into one bundle.
//
// Requester side, indexed by port (0 = first requester, 1 = second):
//   req[p]      request, held until gnt[p]
//   cmd[p]      requested command (NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3)
//   addr[p]     line address
//   wdata[p]    write beat, taken while wready[p]=1
//   gnt[p]      one-cycle pulse: command accepted
//   wready[p]   current write beat is taken this cycle
//   rvalid[p]   rdata carries a read beat this cycle
//   done[p]     one-cycle pulse: transaction finished
//   rdata       shared read beat, qualified by rvalid[p]
//   err         one-cycle pulse with done[p] on a watchdog abort
// Memory side:
//   m_cmd, m_addr, m_wdata, m_wdata_oe   driven by the arbiter
//   m_resp, m_rdata                      driven by the memory controller
//
// Modports: master = arbiter view, slave = requesters + memory view.
interface bus2_arb_if #(
    parameter int CMD_W  = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) ();
    logic [1:0]        req;
    logic [CMD_W-1:0]  cmd   [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        gnt;
    logic [1:0]        wready;
    logic [1:0]        rvalid;
    logic [1:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [CMD_W-1:0]  m_cmd;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wdata_oe;
    logic              m_resp;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  req, cmd, addr, wdata, m_resp, m_rdata,
        output gnt, wready, rvalid, done, rdata, err,
               m_cmd, m_addr, m_wdata, m_wdata_oe
    );

    modport slave (
        output req, cmd, addr, wdata, m_resp, m_rdata,
        input  gnt, wready, rvalid, done, rdata, err,
               m_cmd, m_addr, m_wdata, m_wdata_oe
    );
endinterface

// File: rtl/bus2_arbiter.sv
// bus2_arbiter: two-port round-robin arbiter and phase sequencer for the bus2
// cache <-> memory-controller line bus. Latches the winning requester's command
// and line address, then walks CMD -> write beats / read beats -> response ->
// turnaround, steering data between the granted port and the memory side.
//
// Ports:
//   clk_i   clock, all state on posedge
//   rst_i   asynchronous active-high reset
//   bus     bus2_arb_if.master (requester handshakes + memory-side bus)
//
// Optional feature macro: BUS2_ARB_TIMEOUT_EN
//   defined   : response watchdog; TIMEOUT cycles without M_RESP in WAIT_RESP or
//               RBEAT forces TURN with DONE and ERR pulsing together.
//   undefined : no watchdog, ERR tied low, the arbiter waits for M_RESP forever.
module bus2_arbiter #(
    parameter int CMD_W   = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bus2_arb_if.master   bus
);
    localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(3);

    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WBEAT,
        ST_WAIT_RESP,
        ST_RBEAT,
        ST_TURN
    } state_t;

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              gidx_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        req_valid;
    logic              win_idx;
    logic              timeout_hit;

    // Only line reads and writes are real requests; NOP/RESPONSE are ignored.
    for (genvar gi = 0; gi < 2; gi++) begin : g_valid
        assign req_valid[gi] = bus.req[gi] &&
                               ((bus.cmd[gi] == CMD_READ) || (bus.cmd[gi] == CMD_WRITE));
    end

    // Contest goes to the port not granted last; otherwise the sole requester.
    assign win_idx = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    // ---------------------------------------------------------------- watchdog
`ifdef BUS2_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q;
    logic            waiting;

    assign waiting = (state_q == ST_WAIT_RESP) || (state_q == ST_RBEAT);

    // wd_q = cycles elapsed since the last beat (or since the command phase),
    // so a beat reloads 1 for the following cycle. The abort decision is taken
    // in the cycle where that count reaches TIMEOUT-1, which puts TURN exactly
    // TIMEOUT cycles after the last beat.
    always_comb begin
        wd_d = '0;
        if (waiting && !bus.m_resp) begin
            wd_d = wd_q + 1'b1;
        end else if ((state_q != ST_IDLE) && (state_q != ST_TURN)) begin
            wd_d = WD_W'(1);
        end
    end

    assign timeout_hit = waiting && !bus.m_resp && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= timeout_hit;
        end
    end

    assign bus.err = err_q && (state_q == ST_TURN);
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign bus.err        = 1'b0;
`endif

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                state_d = (cmd_q == CMD_WRITE) ? ST_WBEAT : ST_RBEAT;
            end
            ST_WBEAT: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.m_resp || timeout_hit) begin
                    state_d = ST_TURN;
                end
            end
            ST_RBEAT: begin
                if ((bus.m_resp && (cnt_q == LAST_BEAT)) || timeout_hit) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------- latched command and counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            gidx_q <= 1'b0;
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && (|req_valid)) begin
                cmd_q  <= bus.cmd[win_idx];
                addr_q <= bus.addr[win_idx];
                gidx_q <= win_idx;
                last_q <= win_idx;
            end
            case (state_q)
                ST_CMD:   cnt_q <= '0;
                ST_WBEAT: cnt_q <= cnt_q + 1'b1;
                ST_RBEAT: begin
                    if (bus.m_resp) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------------- outputs
    logic [1:0]        gnt;
    logic [1:0]        wready;
    logic [1:0]        rvalid;
    logic [1:0]        done;
    logic [CMD_W-1:0]  m_cmd;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wdata_oe;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        gnt        = '0;
        wready     = '0;
        rvalid     = '0;
        done       = '0;
        m_cmd      = CMD_NOP;
        m_wdata    = '0;
        m_wdata_oe = 1'b0;
        rdata      = '0;
        case (state_q)
            ST_CMD: begin
                m_cmd       = cmd_q;
                gnt[gidx_q] = 1'b1;
            end
            ST_WBEAT: begin
                // Write data is a straight passthrough from the granted port.
                m_wdata        = bus.wdata[gidx_q];
                m_wdata_oe     = 1'b1;
                wready[gidx_q] = 1'b1;
            end
            ST_RBEAT: begin
                rvalid[gidx_q] = bus.m_resp;
                rdata          = bus.m_rdata;
            end
            ST_TURN: begin
                done[gidx_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.gnt        = gnt;
    assign bus.wready     = wready;
    assign bus.rvalid     = rvalid;
    assign bus.done       = done;
    assign bus.rdata      = rdata;
    assign bus.m_cmd      = m_cmd;
    assign bus.m_addr     = addr_q;
    assign bus.m_wdata    = m_wdata;
    assign bus.m_wdata_oe = m_wdata_oe;
endmodule
